exp_result_bcd: RTL and testbench

- Downstream stage of the `exponential` unit.
- On the unit's `done` pulse, captures the result: `intpart` (2-bit integer) and `fracpart` (16-bit unsigned binary fraction, value = fracpart/65536).
- Converts the result to packed BCD by repeated multiply-by-10 of the fraction, one decimal digit per clock.
- Presents one integer digit plus FRAC_DIGITS fraction digits to the display/readout logic with a one-cycle valid pulse.

---
 rtl/exp_result_bcd.sv | 163 ++++++++++++++++
 tb/tb_exp_result_bcd.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/exp_result_bcd.sv
// rtl/exp_result_bcd.sv - BCD conversion stage for the exponential unit result
//
// Captures a 2-bit integer part and a Q0.16 fraction on done_in. It then
// produces FRAC_DIGITS decimal fraction digits by repeatedly multiplying
// the fraction by 10, one digit per clock.
//
// Optional feature macro: EXP_BCD_ROUND_EN
//   When defined, one extra guard digit is computed and a ROUND state
//   rounds half-up. The carry can ripple through every fraction digit into
//   int_digit. When undefined, the result is truncated.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   done_in      in   capture trigger, sampled only in IDLE
//   intpart      in   [1:0]  integer part of the result
//   fracpart     in   [15:0] unsigned Q0.16 fractional part
//   busy         out  high whenever a conversion is in progress (state != IDLE)
//   valid        out  one-cycle pulse when the digits are final
//   int_digit    out  [3:0]  BCD integer digit
//   frac_digits  out  [4*FRAC_DIGITS-1:0] packed BCD, tenths in the top nibble
module exp_result_bcd #(
    parameter int FRAC_DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [1:0]                 intpart,
    input  logic [15:0]                fracpart,
    output logic                       busy,
    output logic                       valid,
    output logic [3:0]                 int_digit,
    output logic [4*FRAC_DIGITS-1:0]   frac_digits
);

`ifdef EXP_BCD_ROUND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, OUT = 2'd2, ROUND = 2'd3} state_t;
    // The last CONV cycle yields the guard digit rather than a stored digit.
    localparam logic [3:0] LAST_CNT = 4'(FRAC_DIGITS);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;
    localparam logic [3:0] LAST_CNT = 4'(FRAC_DIGITS - 1);
`endif

    state_t                     state, state_n;
    logic [15:0]                frac_r;
    logic [3:0]                 cnt;
    logic [19:0]                prod;
    logic [3:0]                 digit;
    logic [4*FRAC_DIGITS-1:0]   shifted;

`ifdef EXP_BCD_ROUND_EN
    logic [3:0]                 guard;
    logic [4*FRAC_DIGITS-1:0]   rounded;
    logic                       carry;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (done_in) state_n = CONV;
`ifdef EXP_BCD_ROUND_EN
            CONV:    if (cnt == LAST_CNT) state_n = ROUND;
            ROUND:   state_n = OUT;
`else
            CONV:    if (cnt == LAST_CNT) state_n = OUT;
`endif
            OUT:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == OUT);
    end

    // frac_r * 10 fits in 20 bits. The top nibble is the next decimal digit
    // (always 0..9) and the low 16 bits are the remaining fraction.
    always_comb begin
        prod        = {4'd0, frac_r} * 20'd10;
        digit       = prod[19:16];
        shifted     = frac_digits << 4;
        shifted[3:0] = digit;
    end

`ifdef EXP_BCD_ROUND_EN
    // Add one to the least significant digit. A 9 wraps to 0 and passes the
    // carry upward. Any carry left after the top digit goes to int_digit.
    always_comb begin
        rounded = frac_digits;
        carry   = 1'b1;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            if (carry) begin
                if (rounded[4*i +: 4] == 4'd9) begin
                    rounded[4*i +: 4] = 4'd0;
                end else begin
                    rounded[4*i +: 4] = rounded[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end
`endif

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frac_r      <= '0;
            cnt         <= '0;
            int_digit   <= '0;
            frac_digits <= '0;
`ifdef EXP_BCD_ROUND_EN
            guard       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        frac_r      <= fracpart;
                        int_digit   <= {2'b00, intpart};
                        frac_digits <= '0;
                        cnt         <= '0;
                    end
                end
                CONV: begin
                    frac_r <= prod[15:0];
                    cnt    <= cnt + 4'd1;
`ifdef EXP_BCD_ROUND_EN
                    if (cnt == LAST_CNT) begin
                        guard <= digit;
                    end else begin
                        frac_digits <= shifted;
                    end
`else
                    frac_digits <= shifted;
`endif
                end
`ifdef EXP_BCD_ROUND_EN
                ROUND: begin
                    if (guard >= 4'd5) begin
                        frac_digits <= rounded;
                        int_digit   <= int_digit + {3'b000, carry};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_result_bcd.sv
// tb/tb_exp_result_bcd.sv - directed self-checking bench for exp_result_bcd
module tb_exp_result_bcd;

    localparam int FD = 4;
`ifdef EXP_BCD_ROUND_EN
    localparam int         LAT       = FD + 2;
    localparam logic [3:0] FFFF_INT  = 4'd4;
    localparam logic [15:0] FFFF_FRAC = 16'h0000;
`else
    localparam int         LAT       = FD;
    localparam logic [3:0] FFFF_INT  = 4'd3;
    localparam logic [15:0] FFFF_FRAC = 16'h9999;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          done_in;
    logic [1:0]    intpart;
    logic [15:0]   fracpart;
    logic          busy;
    logic          valid;
    logic [3:0]    int_digit;
    logic [4*FD-1:0] frac_digits;

    int n_checks = 0;
    int n_pass   = 0;

    exp_result_bcd #(.FRAC_DIGITS(FD)) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .intpart     (intpart),
        .fracpart    (fracpart),
        .busy        (busy),
        .valid       (valid),
        .int_digit   (int_digit),
        .frac_digits (frac_digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full conversion. Inputs are scrambled after the capture edge to
    // show that only the captured values matter.
    task automatic convert(input string tag, input logic [1:0] ip, input logic [15:0] fp,
                           input logic [3:0] ei, input logic [15:0] ef);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        done_in = 1'b1; intpart = ip; fracpart = fp;
        @(posedge clk); #1;
        done_in = 1'b0; intpart = ~ip; fracpart = ~fp;
        check({tag, " busy after capture"}, busy, 1);
        cyc = 0;
        busy_ok = 1'b1;
        while (!valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, cyc, LAT);
        check({tag, " busy held"}, busy_ok, 1);
        check({tag, " int_digit"}, int_digit, ei);
        check({tag, " frac_digits"}, frac_digits, ef);
        @(posedge clk); #1;
        check({tag, " valid one cycle"}, valid, 0);
        check({tag, " busy cleared"}, busy, 0);
        check({tag, " int held"}, int_digit, ei);
        check({tag, " frac held"}, frac_digits, ef);
    endtask

    initial begin
        int cyc;
        int n_valid;
        logic [3:0]  got_int;
        logic [15:0] got_frac;

        rst = 1'b0; done_in = 1'b0; intpart = 2'd0; fracpart = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset valid", valid, 0);
        check("reset int", int_digit, 0);
        check("reset frac", frac_digits, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        convert("e_half", 2'd1, 16'hA612, 4'd1, 16'h6487);
        convert("half", 2'd2, 16'h8000, 4'd2, 16'h5000);
        convert("all_ones", 2'd3, 16'hFFFF, FFFF_INT, FFFF_FRAC);
        convert("zero", 2'd0, 16'h0000, 4'd0, 16'h0000);

        // A second done_in during CONV must be ignored.
        @(negedge clk);
        done_in = 1'b1; intpart = 2'd1; fracpart = 16'hA612;
        @(posedge clk); #1;
        done_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        done_in = 1'b1; intpart = 2'd2; fracpart = 16'h8000;
        @(posedge clk); #1;
        done_in = 1'b0;
        n_valid = 0; got_int = 4'hF; got_frac = 16'hFFFF;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                n_valid++;
                got_int = int_digit;
                got_frac = frac_digits;
            end
        end
        check("repulse valid count", n_valid, 1);
        check("repulse int", got_int, 4'd1);
        check("repulse frac", got_frac, 16'h6487);
        check("repulse idle", busy, 0);

        // done_in held high: a new capture happens on the IDLE cycle after OUT.
        @(negedge clk);
        done_in = 1'b1; intpart = 2'd2; fracpart = 16'h8000;
        @(posedge clk); #1;
        cyc = 0;
        while (!valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("held first latency", cyc, LAT);
        check("held first frac", frac_digits, 16'h5000);
        fracpart = 16'hA612; intpart = 2'd1;
        @(posedge clk); #1;
        cyc = 1;
        while (!valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        done_in = 1'b0;
        check("held spacing", cyc, LAT + 2);
        check("held second int", int_digit, 4'd1);
        check("held second frac", frac_digits, 16'h6487);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held released idle", busy, 0);

        // Asynchronous reset in the middle of CONV.
        @(negedge clk);
        done_in = 1'b1; intpart = 2'd1; fracpart = 16'hA612;
        @(posedge clk); #1;
        done_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset valid", valid, 0);
        check("midreset int", int_digit, 0);
        check("midreset frac", frac_digits, 0);
        n_valid = 0;
        repeat (3) begin @(posedge clk); #1; if (valid) n_valid++; end
        rst = 1'b1;
        repeat (LAT + 2) begin @(posedge clk); #1; if (valid) n_valid++; end
        check("midreset no valid", n_valid, 0);
        check("midreset frac stays 0", frac_digits, 0);
        convert("after_reset", 2'd2, 16'h8000, 4'd2, 16'h5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
